// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: software fills a pattern table over an
// Avalon-MM slave, then the block replays it to the LED PIO as an Avalon-MM master.
module led_pattern_sequencer #(
  parameter int DWELL_W = 24,
  parameter int STEPS   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  localparam int         PIDX_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [3:0] STEPS_4 = 4'(STEPS);
  localparam logic [2:0] LEN_MAX = 3'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t             state_reg, state_next;
  logic               run_reg, loop_reg, done_reg;
  logic [DWELL_W-1:0] dwell_reg, cnt_reg, cnt_next;
  logic [2:0]         len_reg, idx_reg, idx_next;
  logic [7:0]         pattern_reg [STEPS];
  logic               m_chipselect_reg;
  logic [7:0]         m_pattern_reg;
  logic               done_set, run_clr;

  logic       wr_en, wr_ctrl, wr_dwell, wr_len, wr_status, pat_in_range;
  logic [2:0] len_wr;

  assign wr_en        = s_chipselect & ~s_write_n;
  assign wr_ctrl      = wr_en && (s_address == 4'd0);
  assign wr_dwell     = wr_en && (s_address == 4'd1);
  assign wr_len       = wr_en && (s_address == 4'd2);
  assign wr_status    = wr_en && (s_address == 4'd3);
  assign pat_in_range = s_address[3] && ({1'b0, s_address[2:0]} < STEPS_4);
  // Lengths beyond the table are clamped on write so LEN always reads back usable.
  assign len_wr       = ({1'b0, s_writedata[2:0]} >= STEPS_4) ? LEN_MAX : s_writedata[2:0];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    done_set   = 1'b0;
    run_clr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run_reg) begin
          idx_next   = 3'd0;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          cnt_next   = dwell_reg;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!run_reg) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - DWELL_W'(1);
        end else if (idx_reg == len_reg) begin
          done_set = 1'b1;
          if (loop_reg) begin
            idx_next   = 3'd0;
            state_next = WRITE;
          end else begin
            run_clr    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          idx_next   = idx_reg + 3'd1;
          state_next = WRITE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      idx_reg          <= 3'd0;
      cnt_reg          <= '0;
      m_chipselect_reg <= 1'b0;
      m_pattern_reg    <= 8'd0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      cnt_reg          <= cnt_next;
      m_chipselect_reg <= (state_next == WRITE);
      // Data is captured on entry to WRITE and held for the whole stall.
      if (state_next == WRITE) begin
        if (state_reg != WRITE) m_pattern_reg <= pattern_reg[idx_next[PIDX_W-1:0]];
      end else begin
        m_pattern_reg <= 8'd0;
      end
    end
  end

  // A software write to CTRL overrides the hardware clear of run in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg   <= 1'b0;
      loop_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dwell_reg <= '0;
      len_reg   <= 3'd0;
    end else begin
      if (wr_ctrl) begin
        run_reg  <= s_writedata[0];
        loop_reg <= s_writedata[1];
      end else if (run_clr) begin
        run_reg <= 1'b0;
      end
      if (done_set)                          done_reg <= 1'b1;
      else if (wr_status && s_writedata[8])  done_reg <= 1'b0;
      if (wr_dwell) dwell_reg <= s_writedata[DWELL_W-1:0];
      if (wr_len)   len_reg   <= len_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STEPS; i++) pattern_reg[i] <= 8'd0;
    end else if (wr_en && pat_in_range) begin
      pattern_reg[s_address[PIDX_W-1:0]] <= s_writedata[7:0];
    end
  end

  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      4'd0:    s_readdata = {29'd0, busy, loop_reg, run_reg};
      4'd1:    s_readdata = 32'(dwell_reg);
      4'd2:    s_readdata = {29'd0, len_reg};
      4'd3:    s_readdata = {23'd0, done_reg, 5'd0, idx_reg};
      default: if (pat_in_range) s_readdata = {24'd0, pattern_reg[s_address[PIDX_W-1:0]]};
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign m_address    = 2'd0;
  assign m_chipselect = m_chipselect_reg;
  assign m_write_n    = ~m_chipselect_reg;
  assign m_writedata  = {24'd0, m_pattern_reg};

endmodule
